// File: rtl/ram_port_arbiter.sv
// Shares a serial external-RAM pin interface among NUM_REQ requesters.
// Define RAM_ARB_RR_EN for round-robin among requesters 1..NUM_REQ-1.
module ram_port_arbiter #(
    parameter int RAM_PINS     = 4,
    parameter int NUM_REQ      = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [16*NUM_REQ-1:0]   req_addr,
    output logic [NUM_REQ-1:0]      grant,
    output logic [15:0]             rdata,
    output logic                    rvalid,
    output logic [(NUM_REQ>1 ? $clog2(NUM_REQ) : 1)-1:0] rid,
    output logic                    busy,
    output logic [RAM_PINS-1:0]     addr_pins,
    input  logic [RAM_PINS-1:0]     data_pins
);

    localparam int RW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int B    = 16 / RAM_PINS;
    localparam int CMAX = (B > READ_LATENCY) ? B : READ_LATENCY;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ADDR,
        S_WAIT,
        S_DATA
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [15:0]         r_addr;
    logic [15:0]         r_shift;
    logic [RW-1:0]       r_id;
    logic [RW-1:0]       w_win;
    logic                w_any;
    logic                w_found;
    logic [15:0]         w_shift_nxt;
    logic [RAM_PINS-1:0] w_addr_pins;
`ifdef RAM_ARB_RR_EN
    logic [RW-1:0]       r_ptr;
    int                  v_idx;
`endif

    // Requester 0 always wins; the rest are searched fixed or round-robin.
    always_comb begin
        w_any   = |req;
        w_win   = '0;
        w_found = 1'b0;
`ifdef RAM_ARB_RR_EN
        v_idx   = 0;
`endif
        if (!req[0]) begin
`ifdef RAM_ARB_RR_EN
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                v_idx = ((int'(r_ptr) - 1 + k) % (NUM_REQ - 1)) + 1;
                if (!w_found && req[v_idx]) begin
                    w_found = 1'b1;
                    w_win   = RW'(v_idx);
                end
            end
`else
            for (int k = 1; k < NUM_REQ; k++) begin
                if (!w_found && req[k]) begin
                    w_found = 1'b1;
                    w_win   = RW'(k);
                end
            end
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_pins = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) w_state_nxt = S_HDR;
            end
            S_HDR: begin
                w_addr_pins = RAM_PINS'(1);
                w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                w_addr_pins = r_addr[15 -: RAM_PINS];
                if (r_cnt == CW'(B - 1))
                    w_state_nxt = (READ_LATENCY > 0) ? S_WAIT : S_DATA;
            end
            S_WAIT: begin
                if (r_cnt == CW'(READ_LATENCY - 1)) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (r_cnt == CW'(B - 1)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_shift_nxt = (r_shift << RAM_PINS) | 16'(data_pins);
    assign addr_pins   = w_addr_pins;
    assign busy        = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_shift <= '0;
            r_id    <= '0;
            grant   <= '0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rid     <= '0;
`ifdef RAM_ARB_RR_EN
            r_ptr   <= RW'(1);
`endif
        end else begin
            r_state <= w_state_nxt;
            // Counter restarts on every state change.
            r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + CW'(1);
            grant   <= '0;
            rvalid  <= 1'b0;
            if (r_state == S_IDLE && w_any) begin
                grant  <= NUM_REQ'(1) << w_win;
                r_addr <= req_addr[16*w_win +: 16];
                r_id   <= w_win;
`ifdef RAM_ARB_RR_EN
                if (w_win != '0)
                    r_ptr <= (w_win == RW'(NUM_REQ - 1)) ? RW'(1) : w_win + RW'(1);
`endif
            end
            if (r_state == S_ADDR) r_addr <= r_addr << RAM_PINS;
            if (r_state == S_DATA) begin
                r_shift <= w_shift_nxt;
                if (w_state_nxt == S_IDLE) begin
                    rvalid <= 1'b1;
                    rdata  <= w_shift_nxt;
                    rid    <= r_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a serial RAM model.
// Grant and response expectations are queued; monitors pop and compare.
module tb_ram_port_arbiter;

    localparam int RP = 4;
    localparam int NR = 4;
    localparam int RL = 2;
    localparam int B  = 16 / RP;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [16*NR-1:0]  req_addr;
    logic [NR-1:0]     grant;
    logic [15:0]       rdata;
    logic              rvalid;
    logic [1:0]        rid;
    logic              busy;
    logic [RP-1:0]     addr_pins;
    logic [RP-1:0]     data_pins;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [NR-1:0] exp_grant[$];
    logic [17:0]   exp_resp[$];
    logic [17:0]   m_r;
    logic [NR-1:0] m_g;

    ram_port_arbiter #(
        .RAM_PINS(RP),
        .NUM_REQ(NR),
        .READ_LATENCY(RL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_addr(req_addr),
        .grant(grant),
        .rdata(rdata),
        .rvalid(rvalid),
        .rid(rid),
        .busy(busy),
        .addr_pins(addr_pins),
        .data_pins(data_pins)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ram_word(input logic [15:0] a);
        return (a == 16'hA5C3) ? 16'h1234 : ~a;
    endfunction

    // Serial RAM: header is the cycle grant is high, then B address beats.
    initial begin
        logic [15:0] a;
        logic [15:0] w;
        data_pins = '0;
        forever begin
            @(negedge clk);
            if (!reset && grant != '0) begin
                a = '0;
                for (int i = 0; i < B; i++) begin
                    @(negedge clk);
                    a = (a << RP) | 16'(addr_pins);
                end
                w = ram_word(a);
                repeat (RL) @(negedge clk);
                for (int i = 0; i < B; i++) begin
                    @(negedge clk);
                    data_pins = RP'(w >> (16 - RP * (i + 1)));
                end
                @(negedge clk);
                data_pins = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && rvalid) begin
            if (exp_resp.size() == 0) begin
                chk("unexpected_rvalid", {31'b0, rvalid}, 32'h0);
            end else begin
                m_r = exp_resp.pop_front();
                chk("rid", {30'b0, rid}, {30'b0, m_r[17:16]});
                chk("rdata", {16'b0, rdata}, {16'b0, m_r[15:0]});
            end
        end
        if (!reset && grant != '0) begin
            if (exp_grant.size() == 0) begin
                chk("unexpected_grant", {28'b0, grant}, 32'h0);
            end else begin
                m_g = exp_grant.pop_front();
                chk("grant", {28'b0, grant}, {28'b0, m_g});
            end
        end
    end

    task automatic wait_grant(output int g);
        g = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (grant != '0) begin
                g = cyc;
                return;
            end
        end
        n_chk++;
        n_err++;
        $display("FAIL grant_timeout: got none expected a grant within 40 cycles");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy && exp_resp.size() == 0) return;
        end
        n_chk++;
        n_err++;
        $display("FAIL idle_timeout: busy=%0b pending=%0d expected idle",
                 busy, exp_resp.size());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g, gp;
        logic [3:0] nib[4];
        nib = '{4'hA, 4'h5, 4'hC, 4'h3};
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", {28'b0, grant}, 32'h0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
        chk("rst_rdata", {16'b0, rdata}, 32'h0);
        chk("rst_rid", {30'b0, rid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_addr_pins", {28'b0, addr_pins}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Single request from requester 1
        req_addr[31:16] = 16'hA5C3;
        req = 4'b0010;
        exp_grant.push_back(4'b0010);
        exp_resp.push_back({2'd1, 16'h1234});
        wait_grant(g);
        req = '0;
        chk("hdr_pins", {28'b0, addr_pins}, 32'h1);
        chk("hdr_busy", {31'b0, busy}, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("addr_beat", {28'b0, addr_pins}, {28'b0, nib[k-1]});
        end
        for (int k = 5; k <= 8 + RL; k++) begin
            @(negedge clk);
            chk("mid_rvalid", {31'b0, rvalid}, 32'h0);
            chk("mid_pins", {28'b0, addr_pins}, 32'h0);
        end
        @(negedge clk);
        chk("done_rvalid", {31'b0, rvalid}, 32'h1);
        chk("done_idle", {31'b0, busy}, 32'h0);
        @(negedge clk);
        chk("hold_rdata", {16'b0, rdata}, 32'h1234);
        chk("pulse_rvalid", {31'b0, rvalid}, 32'h0);

        // Requester 0 priority with all requests held
        req_addr = {16'h3333, 16'h2222, 16'h1111, 16'h0F0F};
        for (int n = 0; n < 3; n++) begin
            exp_grant.push_back(4'b0001);
            exp_resp.push_back({2'd0, 16'hF0F0});
        end
        req = 4'b1111;
        gp = 0;
        for (int n = 0; n < 3; n++) begin
            wait_grant(g);
            if (n > 0) chk("prio_period", g - gp, 32'd12);
            gp = g;
        end
        req = '0;
        wait_idle();

        // Reset during DATA aborts with no rvalid
        req_addr[31:16] = 16'h4444;
        req = 4'b0010;
        exp_grant.push_back(4'b0010);
        wait_grant(g);
        req = '0;
        repeat (6 + RL) @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_grant", {28'b0, grant}, 32'h0);
        chk("abort_rvalid", {31'b0, rvalid}, 32'h0);
        chk("abort_rdata", {16'b0, rdata}, 32'h0);
        chk("abort_rid", {30'b0, rid}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_pins", {28'b0, addr_pins}, 32'h0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        req_addr[63:48] = 16'h3C3C;
        req = 4'b1000;
        exp_grant.push_back(4'b1000);
        exp_resp.push_back({2'd3, 16'hC3C3});
        wait_grant(g);
        req = '0;
        wait_idle();

        // Contention among requesters 1..3
        req_addr = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
`ifdef RAM_ARB_RR_EN
        exp_grant.push_back(4'b0010);
        exp_resp.push_back({2'd1, 16'hEEEE});
        exp_grant.push_back(4'b0100);
        exp_resp.push_back({2'd2, 16'hDDDD});
        exp_grant.push_back(4'b1000);
        exp_resp.push_back({2'd3, 16'hCCCC});
        exp_grant.push_back(4'b0010);
        exp_resp.push_back({2'd1, 16'hEEEE});
`else
        for (int n = 0; n < 4; n++) begin
            exp_grant.push_back(4'b0010);
            exp_resp.push_back({2'd1, 16'hEEEE});
        end
`endif
        req = 4'b1110;
        for (int n = 0; n < 4; n++) begin
            wait_grant(g);
            if (n > 0) chk("cont_period", g - gp, 32'd12);
            gp = g;
        end
        req = '0;
        wait_idle();

        // Back-to-back from requester 2 at address 0
        req_addr[47:32] = 16'h0000;
        req = 4'b0100;
        for (int n = 0; n < 2; n++) begin
            exp_grant.push_back(4'b0100);
            exp_resp.push_back({2'd2, 16'hFFFF});
        end
        wait_grant(g);
        chk("b2b_hdr", {28'b0, addr_pins}, 32'h1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("b2b_pins", {28'b0, addr_pins}, (k == 12) ? 32'h1 : 32'h0);
        end
        chk("b2b_regrant", {28'b0, grant}, 32'h4);
        req = '0;
        wait_idle();

        chk("sb_resp_empty", exp_resp.size(), 32'd0);
        chk("sb_grant_empty", exp_grant.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
